ssd_capture: RTL and testbench
==============================

# ssd_capture

Seven-segment readback monitor: the receiving end of the segment-display interface. It samples a multiplexed, active-low seven-segment bus (segment lines plus digit enables) and debounces each digit's glyph. It decodes each glyph back to its hex nibble and presents the reconstructed display value as a register word. It sits on the display pins, alongside the segment driver, so that self-test logic and the verification harness can confirm what is actually shown.

## Interface
- `DIGITS`, 4: number of multiplexed digits; legal range 1–8.
- `STABLE`, 4: consecutive identical registered samples required before capture; minimum 2.
- `TIMEOUT`, 1000000: cycles without a capture after which a digit is declared stale.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `seg_n`  in  8  segment lines, active-low; bit0=a … bit6=g, bit7=dp (dp is ignored).
- `an_n`  in  DIGITS  digit enables, active-low; bit d low selects digit d.
- `err_clr`  in  1  single-cycle pulse that clears `err`.
- `value`  out  4*DIGITS  decoded nibbles; digit d occupies `value[4d+3:4d]`.
- `digit_valid`  out  DIGITS  1 = digit d holds a fresh, legal glyph.
- `err`  out  1  sticky flag: an illegal glyph was captured.
- `upd`  out  1  one-cycle pulse: `value` or `digit_valid` changed.

## Operation
- Input stage: `seg_n[6:0]` and `an_n` are registered every cycle (`s_seg`, `s_an`). All decisions use the registered copies.
- The glyph table is active-high on ~`s_seg`:
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07
  - 8:7F, 9:6F, A:77, b:7C, C:39, d:5E, E:79, F:71
- All-off (~`s_seg` = 00) is BLANK. Any other pattern is ILLEGAL.
- FSM states:
  - IDLE: `s_an` does not have exactly one bit low.
  - TRACK: exactly one bit low; the stability counter is counting.
  - LOCKED: captured; waiting for a change.
- FSM transitions:
  - Any cycle in which {`s_an`, `s_seg`} differs from the previous registered sample: counter := 1; go to TRACK if `s_an` is one-hot-low, else go to IDLE.
  - In TRACK with an unchanged sample: counter increments. When the counter reaches `STABLE`, capture and go to LOCKED.
  - LOCKED does not capture again until the sample changes.
- Capture for digit d:
  - Legal glyph: `value[d]` := nibble, `digit_valid[d]` := 1, and the stale timer for d := 0.
  - BLANK: `digit_valid[d]` := 0; `value[d]` is unchanged; the stale timer is reset.
  - ILLEGAL: `digit_valid[d]` := 0, `err` := 1; `value[d]` is unchanged; the stale timer is reset.
- Stale timers:
  - One counter per digit, saturating at `TIMEOUT`. It counts every cycle while `digit_valid[d]` = 1.
  - On reaching `TIMEOUT`, `digit_valid[d]` := 0.
- `upd` is registered. It is high for exactly one cycle after any edge on which `value` or `digit_valid` changed. A capture that rewrites an identical nibble with `digit_valid` already 1 produces no `upd`.
- Simultaneous events:
  - Capture and timeout on the same digit in the same cycle: capture wins.
  - `err_clr` and an ILLEGAL capture in the same cycle: `err` remains 1.
- Arithmetic widths:
  - Stability counter: clog2(`STABLE`+1) bits, saturating.
  - Stale counters: clog2(`TIMEOUT`+1) bits.

## Timing
- Reset values:
  - `value` = 0, `digit_valid` = 0, `err` = 0, `upd` = 0.
  - FSM in IDLE; all counters 0.
  - `s_an` = all-ones and `s_seg` = all-ones (blank, no digit).
- `rst` asserted mid-TRACK or mid-LOCKED: everything returns to reset values on that edge. A capture due on the same edge is discarded.
- Capture latency: inputs are applied before edge 0 and held. `s_*` loads at edge 0. `value`/`digit_valid`/`err` update at edge `STABLE`. `upd` is high for the cycle following edge `STABLE`.
- A glyph held for fewer than `STABLE` registered samples is never captured.
- Stale timeout: `digit_valid[d]` falls `TIMEOUT` cycles after its last capture edge, with no intervening capture of digit d.

## Test plan
- Reset, then `an_n`=1110, `seg_n`=~7'h5B held, `STABLE`=4 → at edge 4: `value[3:0]`=2, `digit_valid`=0001, `upd` pulse one cycle later. No further `upd` while held.
- Scan digits 0–3 with glyphs 7F, 7C, 39, 71, each held 6 cycles → `value`=16'hFCB8, `digit_valid`=1111, four `upd` pulses.
- `seg_n` toggles between ~06 and ~4F every 3 cycles on digit 1 → no capture, `digit_valid`=0, no `upd`.
- Glyph ~7'h55 held on digit 2 → `err`=1, `digit_valid[2]`=0. Pulse `err_clr` together with a second ILLEGAL capture → `err` stays 1. Pulse `err_clr` alone → `err`=0.
- `TIMEOUT`=20: capture digit 0, then drive `an_n`=1111 → `digit_valid[0]` falls 20 cycles after the capture edge, with one `upd` pulse.
- Assert `rst` at edge 3 of a 4-sample capture → no capture, all outputs 0, FSM IDLE.

Source files
------------

// File: rtl/ssd_capture_if.sv
// ssd_capture_if: display-pin bus between a segment driver and the readback monitor
interface ssd_capture_if #(parameter int DIGITS = 4);
  logic [7:0]          seg_n;
  logic [DIGITS-1:0]   an_n;
  logic                err_clr;
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   digit_valid;
  logic                err;
  logic                upd;
  modport master (output seg_n, an_n, err_clr, input value, digit_valid, err, upd);
  modport slave  (input seg_n, an_n, err_clr, output value, digit_valid, err, upd);
endinterface

// File: rtl/ssd_capture.sv
// ssd_capture: debounces a multiplexed active-low 7-segment bus and decodes it back to hex nibbles
module ssd_capture #(
  parameter int DIGITS  = 4,
  parameter int STABLE  = 4,
  parameter int TIMEOUT = 1000000
) (
  input logic          clk,
  input logic          rst,
  ssd_capture_if.slave bus
);
  localparam int CW = $clog2(STABLE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  typedef enum logic [1:0] {IDLE, TRACK, LOCKED} state_t;
  state_t              r_state, w_state_nx;
  logic [6:0]          r_seg, r_prev_seg, w_on;
  logic [DIGITS-1:0]   r_an, r_prev_an;
  logic [CW-1:0]       r_cnt, w_cnt_nx;
  logic                w_chg, w_cap, w_legal, w_blank;
  logic [3:0]          w_nib;
  logic [IW-1:0]       w_idx;
  logic [4*DIGITS-1:0] r_value, w_value_nx;
  logic [DIGITS-1:0]   r_valid, w_valid_nx;
  logic [TW-1:0]       r_tmr [DIGITS];
  logic [TW-1:0]       w_tmr_nx [DIGITS];
  logic                r_err, r_upd;
  logic                w_dp_unused;
  assign w_dp_unused = bus.seg_n[7];
  assign w_chg   = {r_an, r_seg} != {r_prev_an, r_prev_seg};
  assign w_on    = ~r_seg;
  assign w_blank = w_on == 7'h00;
  // register the pins and keep the previous sample for change detection
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg      <= '1;
      r_an       <= '1;
      r_prev_seg <= '1;
      r_prev_an  <= '1;
    end else begin
      r_seg      <= bus.seg_n[6:0];
      r_an       <= bus.an_n;
      r_prev_seg <= r_seg;
      r_prev_an  <= r_an;
    end
  end
  // stability tracking: any change restarts the count, a full run captures once
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_cap      = 1'b0;
    if (w_chg) begin
      w_cnt_nx   = CW'(1);
      w_state_nx = $onehot(~r_an) ? TRACK : IDLE;
    end else if (r_state == TRACK) begin
      w_cnt_nx = r_cnt + 1'b1;
      if (w_cnt_nx == CW'(STABLE)) begin
        w_cap      = 1'b1;
        w_state_nx = LOCKED;
      end
    end
  end
  // glyph to nibble lookup on the active-high segment pattern
  always_comb begin
    w_nib   = 4'h0;
    w_legal = 1'b1;
    case (w_on)
      7'h3F: w_nib = 4'h0;
      7'h06: w_nib = 4'h1;
      7'h5B: w_nib = 4'h2;
      7'h4F: w_nib = 4'h3;
      7'h66: w_nib = 4'h4;
      7'h6D: w_nib = 4'h5;
      7'h7D: w_nib = 4'h6;
      7'h07: w_nib = 4'h7;
      7'h7F: w_nib = 4'h8;
      7'h6F: w_nib = 4'h9;
      7'h77: w_nib = 4'hA;
      7'h7C: w_nib = 4'hB;
      7'h39: w_nib = 4'hC;
      7'h5E: w_nib = 4'hD;
      7'h79: w_nib = 4'hE;
      7'h71: w_nib = 4'hF;
      default: w_legal = 1'b0;
    endcase
  end
  // position of the single low enable bit
  always_comb begin
    w_idx = '0;
    for (int i = 0; i < DIGITS; i++) if (!r_an[i]) w_idx = IW'(i);
  end
  // per-digit stale aging, then capture overrides so a same-cycle capture wins
  always_comb begin
    w_value_nx = r_value;
    w_valid_nx = r_valid;
    for (int i = 0; i < DIGITS; i++) begin
      w_tmr_nx[i] = r_tmr[i];
      if (r_valid[i]) begin
        w_tmr_nx[i] = (r_tmr[i] == TW'(TIMEOUT)) ? r_tmr[i] : r_tmr[i] + 1'b1;
        if (w_tmr_nx[i] == TW'(TIMEOUT)) w_valid_nx[i] = 1'b0;
      end
      if (w_cap && w_idx == IW'(i)) begin
        w_tmr_nx[i]   = '0;
        w_valid_nx[i] = w_legal;
        if (w_legal) w_value_nx[4*i +: 4] = w_nib;
      end
    end
  end
  // state, captured word, timers and flags; reset drops any capture due this edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_value <= '0;
      r_valid <= '0;
      r_err   <= 1'b0;
      r_upd   <= 1'b0;
      for (int i = 0; i < DIGITS; i++) r_tmr[i] <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_value <= w_value_nx;
      r_valid <= w_valid_nx;
      r_err   <= (w_cap && !w_legal && !w_blank) || (r_err && !bus.err_clr);
      r_upd   <= (w_value_nx != r_value) || (w_valid_nx != r_valid);
      for (int i = 0; i < DIGITS; i++) r_tmr[i] <= w_tmr_nx[i];
    end
  end
  assign bus.value       = r_value;
  assign bus.digit_valid = r_valid;
  assign bus.err         = r_err;
  assign bus.upd         = r_upd;
endmodule

// File: tb/tb_ssd_capture.sv
// tb_ssd_capture: directed and random stimulus against a run-length reference model
module tb_ssd_capture;
  localparam int D  = 4;
  localparam int ST = 4;
  localparam int TO = 20;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  ssd_capture_if #(.DIGITS(D)) bus ();
  ssd_capture #(.DIGITS(D), .STABLE(ST), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int errors = 0;
  int upd_cnt = 0;
  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [D+6:0]   m_s;
  int             m_run;
  logic [4*D-1:0] m_value;
  logic [D-1:0]   m_valid;
  logic           m_err, m_upd;
  int             m_last [D];
  int             cyc;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  // reference: a sample run of exactly ST identical one-hot samples captures once
  task automatic model_edge();
    logic [D+6:0]   cur;
    logic [4*D-1:0] ov;
    logic [D-1:0]   odv;
    logic [6:0]     on;
    logic [3:0]     nib;
    int             d;
    bit             legal, illegal;
    cur = {bus.an_n, bus.seg_n[6:0]};
    if (rst) begin
      m_s = '1; m_run = 1; m_value = '0; m_valid = '0; m_err = 0; m_upd = 0; cyc = 0;
      for (int i = 0; i < D; i++) m_last[i] = 0;
      return;
    end
    ov = m_value; odv = m_valid; illegal = 0; cyc++;
    for (int i = 0; i < D; i++) if (m_valid[i] && cyc - m_last[i] >= TO) m_valid[i] = 1'b0;
    if (m_run == ST && $countones(~m_s[D+6:7]) == 1) begin
      d = 0;
      for (int i = 0; i < D; i++) if (!m_s[7+i]) d = i;
      on = ~m_s[6:0]; legal = 0; nib = 0;
      for (int n = 0; n < 16; n++) if (glyph[n] == on) begin legal = 1; nib = 4'(n); end
      m_last[d] = cyc;
      m_valid[d] = legal;
      if (legal) m_value[4*d +: 4] = nib;
      illegal = !legal && on != 7'h00;
    end
    m_err = illegal || (m_err && !bus.err_clr);
    m_upd = (m_value != ov) || (m_valid != odv);
    if (cur == m_s) m_run++;
    else begin m_s = cur; m_run = 1; end
  endtask
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("value", 32'(bus.value), 32'(m_value));
    chk("digit_valid", 32'(bus.digit_valid), 32'(m_valid));
    chk("err", 32'(bus.err), 32'(m_err));
    chk("upd", 32'(bus.upd), 32'(m_upd));
    if (bus.upd === 1'b1) upd_cnt++;
  endtask
  task automatic drive(input logic [D-1:0] an, input logic [6:0] on, input int n);
    bus.an_n = an;
    bus.seg_n = {1'b1, ~on};
    repeat (n) tick();
  endtask
  initial begin
    logic [D-1:0] an;
    logic [6:0] on;
    bus.seg_n = 8'hFF; bus.an_n = '1; bus.err_clr = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_value", 32'(bus.value), 0);
    chk("rst_valid", 32'(bus.digit_valid), 0);
    chk("rst_err", 32'(bus.err), 0);
    chk("rst_upd", 32'(bus.upd), 0);
    upd_cnt = 0;
    drive(4'b1110, 7'h5B, 4);
    chk("t1_early_valid", 32'(bus.digit_valid), 0);
    tick();
    chk("t1_nib", 32'(bus.value[3:0]), 2);
    chk("t1_valid", 32'(bus.digit_valid), 32'b0001);
    chk("t1_upd", 32'(bus.upd), 1);
    repeat (8) tick();
    chk("t1_upd_count", upd_cnt, 1);
    upd_cnt = 0;
    drive(4'b1110, 7'h7F, 6);
    drive(4'b1101, 7'h7C, 6);
    drive(4'b1011, 7'h39, 6);
    drive(4'b0111, 7'h71, 5);
    chk("scan_value", 32'(bus.value), 32'hFCB8);
    chk("scan_valid", 32'(bus.digit_valid), 32'b1111);
    chk("scan_upd_count", upd_cnt, 4);
    drive(4'b1111, 7'h00, 27);
    chk("stale_all", 32'(bus.digit_valid), 0);
    upd_cnt = 0;
    repeat (4) begin
      drive(4'b1101, 7'h06, 3);
      drive(4'b1101, 7'h4F, 3);
    end
    drive(4'b1111, 7'h00, 6);
    chk("toggle_valid", 32'(bus.digit_valid), 0);
    chk("toggle_upd_count", upd_cnt, 0);
    drive(4'b1011, 7'h55, 6);
    chk("ill_err", 32'(bus.err), 1);
    chk("ill_valid2", 32'(bus.digit_valid[2]), 0);
    drive(4'b1011, 7'h2A, 4);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    chk("ill_clr_collide", 32'(bus.err), 1);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    chk("ill_clr_alone", 32'(bus.err), 0);
    drive(4'b1110, 7'h6D, 5);
    chk("to_valid", 32'(bus.digit_valid[0]), 1);
    chk("to_nib", 32'(bus.value[3:0]), 5);
    upd_cnt = 0;
    drive(4'b1111, 7'h00, 19);
    chk("to_before", 32'(bus.digit_valid[0]), 1);
    tick();
    chk("to_fall", 32'(bus.digit_valid[0]), 0);
    chk("to_upd", 32'(bus.upd), 1);
    repeat (3) tick();
    chk("to_upd_count", upd_cnt, 1);
    drive(4'b1101, 7'h66, 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_value", 32'(bus.value), 0);
    chk("mid_rst_valid", 32'(bus.digit_valid), 0);
    chk("mid_rst_err", 32'(bus.err), 0);
    chk("mid_rst_upd", 32'(bus.upd), 0);
    repeat (8) tick();
    repeat (300) begin
      an = ($urandom_range(0, 3) == 0) ? D'($urandom) : ~(D'(1) << $urandom_range(0, D-1));
      on = ($urandom_range(0, 3) == 0) ? 7'($urandom) : glyph[$urandom_range(0, 15)];
      if ($urandom_range(0, 7) == 0) on = 7'h00;
      bus.an_n = an;
      bus.seg_n = {1'($urandom), ~on};
      repeat ($urandom_range(1, 8)) begin
        bus.err_clr = ($urandom_range(0, 9) == 0);
        rst = ($urandom_range(0, 149) == 0);
        tick();
      end
    end
    rst = 1'b0;
    bus.err_clr = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
